// File: rtl/win_count_if.sv
// Bundles the start/stop/sample inputs and the match/status outputs of win_count_fsm.
interface win_count_if #(
   parameter int CH  = 1,
   parameter int PW  = 2,
   parameter int HCW = 8
);
   logic              s;
   logic              stop;
   logic [CH-1:0]     w;
   logic [CH-1:0]     z;
   logic              busy;
   logic [PW-1:0]     win_pos;
   logic [CH*HCW-1:0] hit_cnt;

   modport master (output s, stop, w, input z, busy, win_pos, hit_cnt);
   modport slave  (input s, stop, w, output z, busy, win_pos, hit_cnt);
endinterface

// File: rtl/win_count_fsm.sv
// Multi-channel window-count detector: z pulses one cycle after each WIN-cycle window whose ones-count matches; no backpressure.
// Optional per-channel saturating hit counters under WIN_COUNT_HIT_CNT_EN (otherwise hit_cnt reads 0).
module win_count_fsm #(
   parameter int WIN    = 3,
   parameter int THRESH = 2,
   parameter int MODE   = 0,
   parameter int CH     = 1,
   parameter int HCW    = 8
) (
   input  logic        clk,
   input  logic        reset,
   win_count_if.slave  bus
);
   localparam int PW = (WIN > 1) ? $clog2(WIN) : 1;
   localparam int CW = $clog2(WIN + 1);
   localparam logic [PW-1:0] LAST = PW'(WIN - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   pos_q, pos_d;
   logic [CW-1:0]   cnt_q [CH];
   logic [CW-1:0]   cnt_d [CH];
   logic [CH-1:0]   z_q, z_d;

   function automatic logic match(input logic [CW-1:0] total);
      logic [31:0] t;
      t = 32'(total);
      if (MODE == 1) return t >= 32'(THRESH);
      else           return t == 32'(THRESH);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pos_q   <= '0;
         z_q     <= '0;
         for (int ch = 0; ch < CH; ch++) cnt_q[ch] <= '0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         z_q     <= z_d;
         for (int ch = 0; ch < CH; ch++) cnt_q[ch] <= cnt_d[ch];
      end
   end

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      z_d     = '0;
      for (int ch = 0; ch < CH; ch++) cnt_d[ch] = cnt_q[ch];

      case (state_q)
         IDLE: begin
            // stop in idle also blocks a same-cycle start
            if (bus.s && !bus.stop) begin
               state_d = RUN;
               pos_d   = '0;
               for (int ch = 0; ch < CH; ch++) cnt_d[ch] = '0;
            end
         end
         RUN: begin
            if (bus.stop) begin
               state_d = IDLE;
               pos_d   = '0;
               for (int ch = 0; ch < CH; ch++) cnt_d[ch] = '0;
            end else if (pos_q == LAST) begin
               pos_d = '0;
               for (int ch = 0; ch < CH; ch++) begin
                  z_d[ch]   = match(cnt_q[ch] + CW'(bus.w[ch]));
                  cnt_d[ch] = '0;
               end
            end else begin
               pos_d = pos_q + 1'b1;
               for (int ch = 0; ch < CH; ch++) cnt_d[ch] = cnt_q[ch] + CW'(bus.w[ch]);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.z       = z_q;
      bus.busy    = (state_q == RUN);
      bus.win_pos = pos_q;
   end

`ifdef WIN_COUNT_HIT_CNT_EN
   logic [HCW-1:0] hc_q [CH];

   // saturating; only reset clears it so stop/restart keeps history
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int ch = 0; ch < CH; ch++) hc_q[ch] <= '0;
      end else begin
         for (int ch = 0; ch < CH; ch++)
            if (z_q[ch] && (hc_q[ch] != {HCW{1'b1}})) hc_q[ch] <= hc_q[ch] + 1'b1;
      end
   end

   always_comb begin
      bus.hit_cnt = '0;
      for (int ch = 0; ch < CH; ch++) bus.hit_cnt[ch*HCW +: HCW] = hc_q[ch];
   end
`else
   assign bus.hit_cnt = '0;
`endif

endmodule

// File: tb/tb_win_count_fsm.sv
module tb_win_count_fsm;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   win_count_if #(.CH(1), .PW(2), .HCW(8)) if0 ();
   win_count_if #(.CH(2), .PW(3), .HCW(8)) if1 ();
   win_count_if #(.CH(1), .PW(2), .HCW(2)) if2 ();

   win_count_fsm #(.WIN(3), .THRESH(2), .MODE(0), .CH(1), .HCW(8))
      u0 (.clk(clk), .reset(reset), .bus(if0.slave));
   win_count_fsm #(.WIN(5), .THRESH(4), .MODE(1), .CH(2), .HCW(8))
      u1 (.clk(clk), .reset(reset), .bus(if1.slave));
   win_count_fsm #(.WIN(3), .THRESH(0), .MODE(1), .CH(1), .HCW(2))
      u2 (.clk(clk), .reset(reset), .bus(if2.slave));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] w1_seq [5];
      int         exp_hc;
      w1_seq = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b01};

      reset = 1'b1;
      if0.s = 0; if0.stop = 0; if0.w = '0;
      if1.s = 0; if1.stop = 0; if1.w = '0;
      if2.s = 0; if2.stop = 0; if2.w = '0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_z", 32'(if0.z), 0);
      chk("rst_busy", 32'(if0.busy), 0);
      chk("rst_pos", 32'(if0.win_pos), 0);
      chk("rst_hit", 32'(if0.hit_cnt), 0);
      chk("rst_z_u1", 32'(if1.z), 0);

      // basic exactly-2 window: w = 1,1,0
      if0.s = 1; tick(); if0.s = 0;
      chk("t1_busy_c1", 32'(if0.busy), 1);
      chk("t1_pos_c1", 32'(if0.win_pos), 0);
      if0.w = 1; tick();
      chk("t1_pos_c2", 32'(if0.win_pos), 1);
      chk("t1_z_c2", 32'(if0.z), 0);
      if0.w = 1; if0.s = 1; tick(); if0.s = 0;
      chk("s_in_run_pos", 32'(if0.win_pos), 2);
      if0.w = 0; tick();
      chk("t1_z_c4", 32'(if0.z), 1);
      chk("t1_pos_c4", 32'(if0.win_pos), 0);

      // 1,1,1 rejected, then 1,0,1 accepted back-to-back
      if0.w = 1; tick();
      chk("z_one_cycle", 32'(if0.z), 0);
      tick(); tick();
      chk("exact_rej_3", 32'(if0.z), 0);
      if0.w = 1; tick(); if0.w = 0; tick(); if0.w = 1; tick();
      chk("b2b_z", 32'(if0.z), 1);

      // stop at pos 1 discards the partial window
      if0.w = 1; tick();
      chk("pre_stop_pos", 32'(if0.win_pos), 1);
      if0.stop = 1; tick(); if0.stop = 0;
      chk("stop_busy", 32'(if0.busy), 0);
      chk("stop_z", 32'(if0.z), 0);
      chk("stop_pos", 32'(if0.win_pos), 0);
      if0.stop = 1; if0.s = 1; tick(); if0.stop = 0;
      chk("stop_blocks_s", 32'(if0.busy), 0);
      tick(); if0.s = 0;
      chk("restart_busy", 32'(if0.busy), 1);
      chk("restart_pos", 32'(if0.win_pos), 0);
      if0.w = 1; tick(); tick(); if0.w = 0; tick();
      chk("fresh_cnt_z", 32'(if0.z), 1);

      // stop on the closing edge of a matching window
      if0.w = 1; tick(); tick();
      if0.w = 0; if0.stop = 1; tick(); if0.stop = 0;
      chk("stop_close_z", 32'(if0.z), 0);
      chk("stop_close_busy", 32'(if0.busy), 0);

      // reset on the closing edge of a matching window
      if0.s = 1; tick(); if0.s = 0;
      if0.w = 1; tick(); tick();
      if0.w = 0; reset = 1; tick(); reset = 0;
      chk("rst_close_z", 32'(if0.z), 0);
      chk("rst_close_busy", 32'(if0.busy), 0);
      chk("rst_close_pos", 32'(if0.win_pos), 0);

      // WIN=5, >=4, two channels: ch0 11111 (5), ch1 10110 (3)
      if1.s = 1; tick(); if1.s = 0;
      for (int i = 0; i < 4; i++) begin
         if1.w = w1_seq[i]; tick();
      end
      chk("u1_pos4", 32'(if1.win_pos), 4);
      chk("u1_z_early", 32'(if1.z), 0);
      if1.w = w1_seq[4]; tick();
      chk("u1_z", 32'(if1.z), 32'b01);
      chk("u1_pos_wrap", 32'(if1.win_pos), 0);
      if1.stop = 1; tick(); if1.stop = 0;
      chk("u1_stop_busy", 32'(if1.busy), 0);

      // THRESH=0, >=: every window matches; 2-bit hit counter saturates
      if2.s = 1; tick(); if2.s = 0;
      repeat (3) tick();
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("u2_z_w%0d", k), 32'(if2.z), 1);
         tick();
`ifdef WIN_COUNT_HIT_CNT_EN
         exp_hc = (k > 3) ? 3 : k;
`else
         exp_hc = 0;
`endif
         chk($sformatf("u2_hit_w%0d", k), 32'(if2.hit_cnt), 32'(exp_hc));
         if (k < 4) repeat (2) tick();
      end
      if2.stop = 1; tick(); if2.stop = 0; tick();
      chk("u2_hit_after_stop", 32'(if2.hit_cnt), 32'(exp_hc));
      chk("u2_stop_busy", 32'(if2.busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/win_count_fsm.md
# win_count_fsm

Parametrised, multi-channel window-count detector for the sequential-FSM library. After a start strobe `s` it slices time into back-to-back windows of `WIN` cycles. For each channel it counts the `1`s sampled on `w[ch]` within each window. One cycle after the window closes, it pulses `z[ch]` if the count meets `THRESH` under the selected match mode. This generalises the fixed 3-cycle, exactly-2 detector to any window length, threshold, mode and channel count, and adds a stop control.

## Interface
Parameters:
- `WIN`, default 3: window length in cycles, 2..64.
- `THRESH`, default 2: target count of ones, 0..`WIN`.
- `MODE`, default 0: 0 = match when count == `THRESH`; 1 = match when count >= `THRESH`.
- `CH`, default 1: number of independent `w`/`z` channels, 1..16.
- `HCW`, default 8: width of each hit counter.

Ports:
- `clk` in 1: clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `s` in 1: start; sampled only while idle.
- `stop` in 1: return to idle at the next edge; dominates all but `reset`.
- `w` in `CH`: per-channel sample inputs.
- `z` out `CH`: registered per-channel match pulse.
- `busy` out 1: 1 while windowing is active.
- `win_pos` out `$clog2(WIN)`: index of the current sample cycle within the window.
- `hit_cnt` out `CH*HCW`: per-channel saturating match counters; channel n occupies bits [n*HCW +: HCW].

## Operation
- States: IDLE and RUN, held in the `busy` register. RUN also holds `pos` (0..`WIN-1`), one count register per channel (0..`WIN`) and the `z` register.
- `reset`: `busy`=0, `pos`=0, all counts=0, `z`=0, `hit_cnt`=0.
- IDLE:
  - `z`<=0.
  - `s`=1 → RUN with `pos`=0 and counts=0.
  - `w` is ignored.
- RUN: every cycle samples `w[ch]` at position `pos`.
  - `pos` < `WIN-1`: `cnt[ch]` += `w[ch]`; `pos`++; `z`<=0.
  - `pos` == `WIN-1`: `z[ch]` <= match(`cnt[ch]` + `w[ch]`); `pos`<=0; counts<=0. The next window starts immediately, with no gap cycle.
  - `s` is ignored in RUN.
- Match: with `MODE`=0, total == `THRESH`; with `MODE`=1, total >= `THRESH`. `THRESH`=0 with `MODE`=1 matches every window.
- `stop`=1 in RUN → IDLE: `z`<=0, counts cleared, partial window discarded. `stop` in IDLE has no effect, and `s` is not accepted in that cycle.
- Count arithmetic: width `$clog2(WIN+1)`; never overflows because it is cleared each window.
- Channels are fully independent except for the shared `pos`, `busy` and `stop`.

## Timing
- First sample is taken in the cycle after the edge that accepted `s`.
- `z` asserts in the cycle after the last sample of a window, which is position 0 of the next window. It is high for exactly one cycle per matching window.
- With `WIN`=3, `s` accepted at edge 0: samples at cycles 1, 2, 3 and `z` valid at cycle 4. The next window samples at cycles 4, 5, 6 and its `z` at cycle 7.
- `stop` on the same edge as a window close: `stop` wins, and `z` stays 0.
- `reset` mid-window: all state cleared at that edge, and no `z` is produced.
- `busy` and `win_pos` are registered and reflect the state used for the current cycle's sample.

## Configuration
- `WIN_COUNT_HIT_CNT_EN` defined:
  - Each channel's `hit_cnt` increments on every cycle its `z` is 1.
  - The counter saturates at 2^`HCW`-1.
  - It is cleared only by `reset`; `stop` does not clear it.
- Undefined: `hit_cnt` is tied to 0 and no counter registers are built. The port remains present.

## Test plan
- Default params, `CH`=1: reset, `s`=1 at edge 0, `w`=1,1,0 in cycles 1-3 → `z`=1 in cycle 4 only; `busy`=1 from cycle 1.
- Default params: `w`=1,1,1 then 1,0,1 → `z`=0 at cycle 4, `z`=1 at cycle 7. This confirms exact-match rejects 3 and windows are back-to-back.
- `MODE`=1, `WIN`=5, `THRESH`=4, `CH`=2: `w[0]`=11111, `w[1]`=10110 → `z`=2'b01 one cycle after the window.
- `stop` asserted at `pos`=1 → `busy`=0 next cycle, `z` stays 0. A new `s` then restarts with `pos`=0 and fresh counts.
- `reset` asserted at the window-close edge with a matching count → `z`=0 and all outputs at reset values. `s` pulses during RUN do not restart the window.
- With `WIN_COUNT_HIT_CNT_EN`, `HCW`=2, `THRESH`=0, `MODE`=1: every window matches, and `hit_cnt` goes 1, 2, 3, 3 (saturates). Without the macro, `hit_cnt` stays 0.
